// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline boundary registers.
//  - Stall flag encoding (STOP / NO_STOP)
//  - NOP payload constants (EXE_NOP_OP, ZERO_WORD, NOP_REG_ADDR)
//  - One-hot stage action type produced by stage_ctl
package pipe_stage_reg_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

  typedef enum logic [4:0] {
    ACT_RESET   = 5'b00001,
    ACT_FLUSH   = 5'b00010,
    ACT_BUBBLE  = 5'b00100,
    ACT_ADVANCE = 5'b01000,
    ACT_HOLD    = 5'b10000
  } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_stage_ctl.sv
// stage_ctl: decodes reset, flush and the two relevant stall flags into the
// one-hot action applied to a pipeline boundary register this cycle.
// Ports:
//  rst       in   synchronous reset, active-low
//  flush     in   kill in-flight op
//  stall_up  in   stall flag of the upstream stage
//  stall_dn  in   stall flag of the downstream stage
//  act       out  one-hot stage action
//
// action      | meaning
// ACT_RESET   | reset asserted, load reset values
// ACT_FLUSH   | squash: load NOP, clear held state
// ACT_BUBBLE  | upstream stopped, downstream running: insert NOP
// ACT_ADVANCE | upstream running: capture new payload
// ACT_HOLD    | both stopped: keep payload
module stage_ctl
  import pipe_stage_reg_pkg::*;
(
  input  logic       rst,
  input  logic       flush,
  input  logic       stall_up,
  input  logic       stall_dn,
  output stage_act_e act
);

  always_comb begin
    act = ACT_HOLD;
    if (!rst)
      act = ACT_RESET;
    else if (flush)
      act = ACT_FLUSH;
    else if (stall_up == STOP && stall_dn == NO_STOP)
      act = ACT_BUBBLE;
    else if (stall_up == NO_STOP)
      act = ACT_ADVANCE;
    else
      act = ACT_HOLD;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register between stage STAGE
// and stage STAGE+1. Registers the write-back, HI/LO and load/store payload,
// a valid bit, held multi-cycle state, a forward-tap qualifier and a
// saturating bubble counter.
// Ports:
//  clk, rst            clock; synchronous active-low reset
//  stall, flush        global stall vector, squash request
//  in_* / out_*        payload in, registered payload out
//  mc_i/cnt_i          multi-cycle state in; mc_o/cnt_o held copy
//  fwd_en              forward tap qualifier, from registered outputs only
//  bubble_cnt          saturating count of bubble cycles
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int STAGE   = 3,
  parameter int STALL_W = 6,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 8,
  parameter int MC_W    = 64,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic               in_wreg,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic               in_whilo,
  input  logic [DATA_W-1:0]  in_hi,
  input  logic [DATA_W-1:0]  in_lo,
  input  logic [OP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]  in_mem_addr,
  input  logic [DATA_W-1:0]  in_reg2,
  input  logic [MC_W-1:0]    mc_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_wd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_wdata,
  output logic               out_whilo,
  output logic [DATA_W-1:0]  out_hi,
  output logic [DATA_W-1:0]  out_lo,
  output logic [OP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]  out_mem_addr,
  output logic [DATA_W-1:0]  out_reg2,
  output logic [MC_W-1:0]    mc_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               fwd_en,
  output logic [PERF_W-1:0]  bubble_cnt
);

  localparam logic [OP_W-1:0]   NOP_OP   = OP_W'(EXE_NOP_OP);
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOP_REG_ADDR);

  stage_act_e act;

  // Only stall[STAGE] and stall[STAGE+1] matter; the rest are consumed here.
  logic unused_stall;
  assign unused_stall = ^stall;

  stage_ctl u_stage_ctl (
    .rst      (rst),
    .flush    (flush),
    .stall_up (stall[STAGE]),
    .stall_dn (stall[STAGE+1]),
    .act      (act)
  );

  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        out_valid    <= 1'b0;
        out_wd       <= NOP_ADDR;
        out_wreg     <= 1'b0;
        out_wdata    <= NOP_WORD;
        out_whilo    <= 1'b0;
        out_hi       <= NOP_WORD;
        out_lo       <= NOP_WORD;
        out_aluop    <= NOP_OP;
        out_mem_addr <= NOP_WORD;
        out_reg2     <= NOP_WORD;
      end
      ACT_ADVANCE: begin
        out_valid    <= in_valid;
        out_wd       <= in_wd;
        // An empty slot still carries its fields but must not write anything.
        out_wreg     <= in_wreg & in_valid;
        out_wdata    <= in_wdata;
        out_whilo    <= in_whilo & in_valid;
        out_hi       <= in_hi;
        out_lo       <= in_lo;
        out_aluop    <= in_aluop;
        out_mem_addr <= in_mem_addr;
        out_reg2     <= in_reg2;
      end
      default: ;
    endcase
  end

  // Multi-cycle state is only kept while the upstream stage is stopped.
  always_ff @(posedge clk) begin
    if (act == ACT_BUBBLE || act == ACT_HOLD) begin
      mc_o  <= mc_i;
      cnt_o <= cnt_i;
    end else begin
      mc_o  <= '0;
      cnt_o <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (act == ACT_RESET)
      bubble_cnt <= '0;
    else if (act == ACT_BUBBLE && bubble_cnt != {PERF_W{1'b1}})
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  assign fwd_en = out_valid & out_wreg & (out_wd != NOP_ADDR);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int STAGE   = 3;
  localparam int STALL_W = 6;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 8;
  localparam int MC_W    = 64;
  localparam int CNT_W   = 2;
  localparam int PERF_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [ADDR_W-1:0]  in_wd;
  logic               in_wreg;
  logic [DATA_W-1:0]  in_wdata;
  logic               in_whilo;
  logic [DATA_W-1:0]  in_hi;
  logic [DATA_W-1:0]  in_lo;
  logic [OP_W-1:0]    in_aluop;
  logic [DATA_W-1:0]  in_mem_addr;
  logic [DATA_W-1:0]  in_reg2;
  logic [MC_W-1:0]    mc_i;
  logic [CNT_W-1:0]   cnt_i;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_wd;
  logic               out_wreg;
  logic [DATA_W-1:0]  out_wdata;
  logic               out_whilo;
  logic [DATA_W-1:0]  out_hi;
  logic [DATA_W-1:0]  out_lo;
  logic [OP_W-1:0]    out_aluop;
  logic [DATA_W-1:0]  out_mem_addr;
  logic [DATA_W-1:0]  out_reg2;
  logic [MC_W-1:0]    mc_o;
  logic [CNT_W-1:0]   cnt_o;
  logic               fwd_en;
  logic [PERF_W-1:0]  bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .STAGE(STAGE), .STALL_W(STALL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .OP_W(OP_W), .MC_W(MC_W), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .in_whilo(in_whilo), .in_hi(in_hi), .in_lo(in_lo), .in_aluop(in_aluop),
    .in_mem_addr(in_mem_addr), .in_reg2(in_reg2), .mc_i(mc_i), .cnt_i(cnt_i),
    .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_wdata(out_wdata), .out_whilo(out_whilo), .out_hi(out_hi),
    .out_lo(out_lo), .out_aluop(out_aluop), .out_mem_addr(out_mem_addr),
    .out_reg2(out_reg2), .mc_o(mc_o), .cnt_o(cnt_o), .fwd_en(fwd_en),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop_payload(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".wreg"},  64'(out_wreg),  64'd0);
    chk({tag, ".whilo"}, 64'(out_whilo), 64'd0);
    chk({tag, ".wd"},    64'(out_wd),    64'd0);
    chk({tag, ".wdata"}, 64'(out_wdata), 64'd0);
    chk({tag, ".hi"},    64'(out_hi),    64'd0);
    chk({tag, ".lo"},    64'(out_lo),    64'd0);
    chk({tag, ".aluop"}, 64'(out_aluop), 64'h00);
    chk({tag, ".maddr"}, 64'(out_mem_addr), 64'd0);
    chk({tag, ".reg2"},  64'(out_reg2),  64'd0);
    chk({tag, ".fwd"},   64'(fwd_en),    64'd0);
  endtask

  initial begin
    // 1: reset with all inputs high
    rst = 1'b0; stall = '1; flush = 1'b1; in_valid = 1'b1; in_wd = '1; in_wreg = 1'b1;
    in_wdata = '1; in_whilo = 1'b1; in_hi = '1; in_lo = '1; in_aluop = '1;
    in_mem_addr = '1; in_reg2 = '1; mc_i = '1; cnt_i = '1;
    step();
    step();
    chk_nop_payload("reset");
    chk("reset.mc",     mc_o,              64'd0);
    chk("reset.cnt",    64'(cnt_o),        64'd0);
    chk("reset.bubble", 64'(bubble_cnt),   64'd0);

    // 2: plain advance, 1-cycle latency
    rst = 1'b1; flush = 1'b0; stall = 6'b000000;
    in_valid = 1'b1; in_wd = 5'd5; in_wreg = 1'b1; in_wdata = 32'hDEADBEEF;
    in_whilo = 1'b1; in_hi = 32'h1111_0000; in_lo = 32'h0000_2222; in_aluop = 8'h21;
    in_mem_addr = 32'h0000_0100; in_reg2 = 32'h0000_0055; cnt_i = 2'd3;
    step();
    chk("adv.valid", 64'(out_valid),    64'd1);
    chk("adv.wd",    64'(out_wd),       64'd5);
    chk("adv.wreg",  64'(out_wreg),     64'd1);
    chk("adv.wdata", 64'(out_wdata),    64'hDEADBEEF);
    chk("adv.whilo", 64'(out_whilo),    64'd1);
    chk("adv.hi",    64'(out_hi),       64'h1111_0000);
    chk("adv.lo",    64'(out_lo),       64'h0000_2222);
    chk("adv.aluop", 64'(out_aluop),    64'h21);
    chk("adv.maddr", 64'(out_mem_addr), 64'h100);
    chk("adv.reg2",  64'(out_reg2),     64'h55);
    chk("adv.fwd",   64'(fwd_en),       64'd1);
    chk("adv.mc",    mc_o,              64'd0);
    chk("adv.cnt",   64'(cnt_o),        64'd0);

    // Empty slot on advance: fields captured, side effects suppressed
    in_valid = 1'b0; in_wd = 5'd7; in_wdata = 32'h0000_AAAA;
    step();
    chk("empty.valid", 64'(out_valid), 64'd0);
    chk("empty.wreg",  64'(out_wreg),  64'd0);
    chk("empty.whilo", 64'(out_whilo), 64'd0);
    chk("empty.wd",    64'(out_wd),    64'd7);
    chk("empty.wdata", 64'(out_wdata), 64'h0000_AAAA);
    chk("empty.fwd",   64'(fwd_en),    64'd0);

    // 3: bubble (S=1, D=0)
    in_valid = 1'b1; stall = 6'b001000; mc_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd1;
    step();
    chk_nop_payload("bub");
    chk("bub.mc",     mc_o,            64'h1234_5678_9ABC_DEF0);
    chk("bub.cnt",    64'(cnt_o),      64'd1);
    chk("bub.bubble", 64'(bubble_cnt), 64'd1);

    // 4: capture an op, then hold it for 3 cycles (S=1, D=1)
    stall = 6'b000000; in_wd = 5'd9; in_wdata = 32'hCAFE_F00D;
    step();
    chk("cap.wdata", 64'(out_wdata), 64'hCAFE_F00D);
    stall = 6'b011000; in_wd = 5'd3; in_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      mc_i = 64'h100 + 64'(i); cnt_i = 2'(i);
      step();
      chk("hold.wdata",  64'(out_wdata),  64'hCAFE_F00D);
      chk("hold.wd",     64'(out_wd),     64'd9);
      chk("hold.fwd",    64'(fwd_en),     64'd1);
      chk("hold.mc",     mc_o,            64'h100 + 64'(i));
      chk("hold.cnt",    64'(cnt_o),      64'(i));
      chk("hold.bubble", 64'(bubble_cnt), 64'd1);
    end

    // 5: flush beats S & D, discards mc state, is not a bubble
    flush = 1'b1;
    step();
    chk_nop_payload("flushSD");
    chk("flushSD.mc",     mc_o,            64'd0);
    chk("flushSD.cnt",    64'(cnt_o),      64'd0);
    chk("flushSD.bubble", 64'(bubble_cnt), 64'd1);
    stall = 6'b001000;
    step();
    chk("flushS.valid",  64'(out_valid),  64'd0);
    chk("flushS.bubble", 64'(bubble_cnt), 64'd1);
    chk("flushS.mc",     mc_o,            64'd0);
    flush = 1'b0;

    // Stall bits outside STAGE/STAGE+1 are ignored -> advance
    stall = 6'b100111; in_wd = 5'd4; in_wdata = 32'h0000_0077;
    step();
    chk("ign.wdata",  64'(out_wdata),  64'h77);
    chk("ign.fwd",    64'(fwd_en),     64'd1);
    chk("ign.bubble", 64'(bubble_cnt), 64'd1);

    // Reset mid-operation wins over stall/flush
    rst = 1'b0; stall = 6'b011000; flush = 1'b1;
    step();
    chk_nop_payload("rstmid");
    chk("rstmid.bubble", 64'(bubble_cnt), 64'd0);
    rst = 1'b1; flush = 1'b0;

    // 6: dest r0 disables forwarding; then bubble saturation at 4'hF
    stall = 6'b000000; in_valid = 1'b1; in_wd = 5'd0; in_wreg = 1'b1;
    step();
    chk("r0.valid", 64'(out_valid), 64'd1);
    chk("r0.wreg",  64'(out_wreg),  64'd1);
    chk("r0.fwd",   64'(fwd_en),    64'd0);
    stall = 6'b001000;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat.14", 64'(bubble_cnt), 64'hE);
      if (i == 15) chk("sat.15", 64'(bubble_cnt), 64'hF);
      if (i == 20) chk("sat.20", 64'(bubble_cnt), 64'hF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
